mem_stage: RTL and testbench

- Memory-access pipeline stage, directly upstream of the write-back stage.
- Takes instructions from EX, whose data-SRAM request (if any) was already issued in EX, and waits for the matching data_ok.
- Extracts and sign/zero-extends load data, then hands the result plus an opaque side-band bus (CSR/exception/TLB fields) to WB over a valid/allowin handshake.
- Drops responses belonging to instructions flushed while their request was outstanding.

---
 rtl/mem_stage.sv | 174 +++++++++++++++++
 tb/tb_mem_stage.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for the data-SRAM response of the instruction
// it holds, extracts and extends load data, and passes the result plus side-band to WB.
module mem_stage #(
  parameter int SIDE_W = 140
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_to_mem_valid,
  output logic              mem_allowin,
  input  logic [31:0]       ex_pc,
  input  logic              ex_rf_we,
  input  logic [4:0]        ex_rf_waddr,
  input  logic [31:0]       ex_alu_result,
  input  logic [4:0]        ex_ld_op,
  input  logic              ex_mem_req,
  input  logic              ex_excep,
  input  logic [SIDE_W-1:0] ex_side,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  input  logic              wb_allowin,
  input  logic              wb_flush,
  output logic              mem_to_wb_valid,
  output logic [31:0]       mem_pc,
  output logic              mem_rf_we,
  output logic [4:0]        mem_rf_waddr,
  output logic [31:0]       mem_rf_wdata,
  output logic [SIDE_W-1:0] mem_side,
  output logic              mem_fwd_we,
  output logic [4:0]        mem_fwd_waddr,
  output logic [31:0]       mem_fwd_wdata,
  output logic              mem_ld_pending,
  output logic              mem_excep_out
);

  logic              valid_q, valid_d;
  logic [31:0]       pc_q, pc_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [31:0]       alu_result_q, alu_result_d;
  logic [4:0]        ld_op_q, ld_op_d;
  logic              mem_req_q, mem_req_d;
  logic              excep_q, excep_d;
  logic [SIDE_W-1:0] side_q, side_d;
  logic              buf_valid_q, buf_valid_d;
  logic [31:0]       buf_data_q, buf_data_d;
  logic [1:0]        discard_cnt_q, discard_cnt_d;

  logic        take_ok;
  logic        ready_go;
  logic        buf_set;
  logic        disc_inc;
  logic        disc_dec;
  logic [31:0] raw_data;
  logic [31:0] final_wdata;

  // ld_op is one-hot {w,hu,h,bu,b}; the offset comes from the low address bits.
  function automatic logic [31:0] ld_extract(input logic [4:0]  op,
                                             input logic [1:0]  off,
                                             input logic [31:0] raw);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res;
    byte_v = raw[{off, 3'b000} +: 8];
    half_v = off[1] ? raw[31:16] : raw[15:0];
    res    = raw;
    if (op[0])      res = {{24{byte_v[7]}}, byte_v};
    else if (op[1]) res = {24'h0, byte_v};
    else if (op[2]) res = {{16{half_v[15]}}, half_v};
    else if (op[3]) res = {16'h0, half_v};
    return res;
  endfunction

  // Responses are only ours once every response owed to a flushed request has drained.
  assign take_ok  = data_sram_data_ok && (discard_cnt_q == 2'd0);
  assign ready_go = !mem_req_q || excep_q || buf_valid_q || take_ok;

  assign mem_allowin     = !valid_q || (ready_go && wb_allowin);
  assign mem_to_wb_valid = valid_q && ready_go && !wb_flush;

  assign buf_set  = valid_q && mem_req_q && take_ok && !(mem_to_wb_valid && wb_allowin);
  assign disc_inc = wb_flush && valid_q && mem_req_q && !buf_valid_q && !take_ok;
  assign disc_dec = data_sram_data_ok && (discard_cnt_q != 2'd0);

  assign raw_data    = buf_valid_q ? buf_data_q : data_sram_rdata;
  assign final_wdata = (ld_op_q != 5'd0) ? ld_extract(ld_op_q, alu_result_q[1:0], raw_data)
                                         : alu_result_q;

  always_comb begin
    valid_d       = valid_q;
    pc_d          = pc_q;
    rf_we_d       = rf_we_q;
    waddr_d       = waddr_q;
    alu_result_d  = alu_result_q;
    ld_op_d       = ld_op_q;
    mem_req_d     = mem_req_q;
    excep_d       = excep_q;
    side_d        = side_q;
    buf_valid_d   = buf_valid_q;
    buf_data_d    = buf_data_q;
    discard_cnt_d = discard_cnt_q;

    if (mem_allowin) begin
      valid_d     = ex_to_mem_valid;
      buf_valid_d = 1'b0;
    end
    if (ex_to_mem_valid && mem_allowin) begin
      pc_d         = ex_pc;
      rf_we_d      = ex_rf_we;
      waddr_d      = ex_rf_waddr;
      alu_result_d = ex_alu_result;
      ld_op_d      = ex_ld_op;
      mem_req_d    = ex_mem_req;
      excep_d      = ex_excep;
      side_d       = ex_side;
    end
    // WB is stalled while the response is here: park it so the SRAM need not hold it.
    if (buf_set) begin
      buf_valid_d = 1'b1;
      buf_data_d  = data_sram_rdata;
    end
    if (wb_flush) begin
      valid_d     = 1'b0;
      buf_valid_d = 1'b0;
    end

    case ({disc_inc, disc_dec})
      2'b10:   if (discard_cnt_q != 2'd2) discard_cnt_d = discard_cnt_q + 2'd1;
      2'b01:   discard_cnt_d = discard_cnt_q - 2'd1;
      default: discard_cnt_d = discard_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q       <= 1'b0;
      pc_q          <= 32'h0;
      rf_we_q       <= 1'b0;
      waddr_q       <= 5'h0;
      alu_result_q  <= 32'h0;
      ld_op_q       <= 5'h0;
      mem_req_q     <= 1'b0;
      excep_q       <= 1'b0;
      side_q        <= '0;
      buf_valid_q   <= 1'b0;
      buf_data_q    <= 32'h0;
      discard_cnt_q <= 2'd0;
    end else begin
      valid_q       <= valid_d;
      pc_q          <= pc_d;
      rf_we_q       <= rf_we_d;
      waddr_q       <= waddr_d;
      alu_result_q  <= alu_result_d;
      ld_op_q       <= ld_op_d;
      mem_req_q     <= mem_req_d;
      excep_q       <= excep_d;
      side_q        <= side_d;
      buf_valid_q   <= buf_valid_d;
      buf_data_q    <= buf_data_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  assign mem_pc         = pc_q;
  assign mem_rf_we      = rf_we_q;
  assign mem_rf_waddr   = waddr_q;
  assign mem_rf_wdata   = final_wdata;
  assign mem_side       = side_q;
  assign mem_fwd_we     = valid_q && rf_we_q;
  assign mem_fwd_waddr  = waddr_q;
  assign mem_fwd_wdata  = final_wdata;
  assign mem_ld_pending = valid_q && (ld_op_q != 5'd0) && !ready_go;
  assign mem_excep_out  = valid_q && excep_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: scoreboard of expected WB transfers plus per-scenario cycle checks.
module tb_mem_stage;
  localparam int SIDE_W = 140;

  logic              clk = 1'b0;
  logic              reset;
  logic              ex_to_mem_valid;
  logic              mem_allowin;
  logic [31:0]       ex_pc;
  logic              ex_rf_we;
  logic [4:0]        ex_rf_waddr;
  logic [31:0]       ex_alu_result;
  logic [4:0]        ex_ld_op;
  logic              ex_mem_req;
  logic              ex_excep;
  logic [SIDE_W-1:0] ex_side;
  logic              data_sram_data_ok;
  logic [31:0]       data_sram_rdata;
  logic              wb_allowin;
  logic              wb_flush;
  logic              mem_to_wb_valid;
  logic [31:0]       mem_pc;
  logic              mem_rf_we;
  logic [4:0]        mem_rf_waddr;
  logic [31:0]       mem_rf_wdata;
  logic [SIDE_W-1:0] mem_side;
  logic              mem_fwd_we;
  logic [4:0]        mem_fwd_waddr;
  logic [31:0]       mem_fwd_wdata;
  logic              mem_ld_pending;
  logic              mem_excep_out;

  mem_stage #(.SIDE_W(SIDE_W)) dut (
    .clk(clk), .reset(reset),
    .ex_to_mem_valid(ex_to_mem_valid), .mem_allowin(mem_allowin),
    .ex_pc(ex_pc), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_alu_result(ex_alu_result), .ex_ld_op(ex_ld_op), .ex_mem_req(ex_mem_req),
    .ex_excep(ex_excep), .ex_side(ex_side),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .wb_allowin(wb_allowin), .wb_flush(wb_flush),
    .mem_to_wb_valid(mem_to_wb_valid), .mem_pc(mem_pc), .mem_rf_we(mem_rf_we),
    .mem_rf_waddr(mem_rf_waddr), .mem_rf_wdata(mem_rf_wdata), .mem_side(mem_side),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_waddr(mem_fwd_waddr), .mem_fwd_wdata(mem_fwd_wdata),
    .mem_ld_pending(mem_ld_pending), .mem_excep_out(mem_excep_out)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] LD_B = 5'b00001, LD_BU = 5'b00010, LD_H = 5'b00100,
                         LD_HU = 5'b01000, LD_W = 5'b10000;

  typedef struct packed {
    logic [31:0]       pc;
    logic              rf_we;
    logic [4:0]        waddr;
    logic [31:0]       wdata;
    logic [SIDE_W-1:0] side;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [SIDE_W-1:0] mk_side(input logic [31:0] s);
    return {s[11:0], s, ~s, s ^ 32'hA5A5A5A5, {s[15:0], s[31:16]}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                          input logic [31:0] alu, input logic [4:0] ld, input logic req,
                          input logic exc);
    ex_to_mem_valid = 1'b1;
    ex_pc = pc; ex_rf_we = we; ex_rf_waddr = wa; ex_alu_result = alu;
    ex_ld_op = ld; ex_mem_req = req; ex_excep = exc; ex_side = mk_side(pc);
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                          input logic [31:0] wdata);
    exp_t e;
    e.pc = pc; e.rf_we = we; e.waddr = wa; e.wdata = wdata; e.side = mk_side(pc);
    sb.push_back(e);
  endtask

  task automatic enter(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                       input logic [31:0] alu, input logic [4:0] ld, input logic req,
                       input logic exc);
    drive_ex(pc, we, wa, alu, ld, req, exc);
    tick();
    ex_to_mem_valid = 1'b0;
  endtask

  // Every accepted WB transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && mem_to_wb_valid && wb_allowin) begin
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL sb_unexpected pc=%h wdata=%h (no transfer expected)", mem_pc, mem_rf_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({mem_pc, mem_rf_we, mem_rf_waddr, mem_rf_wdata, mem_side} !==
            {e.pc, e.rf_we, e.waddr, e.wdata, e.side}) begin
          errors = errors + 1;
          $display("FAIL sb_transfer got pc=%h we=%b wa=%0d wdata=%h side=%h exp pc=%h we=%b wa=%0d wdata=%h side=%h",
                   mem_pc, mem_rf_we, mem_rf_waddr, mem_rf_wdata, mem_side,
                   e.pc, e.rf_we, e.waddr, e.wdata, e.side);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    ex_to_mem_valid = 1'b0; ex_pc = '0; ex_rf_we = 1'b0; ex_rf_waddr = '0;
    ex_alu_result = '0; ex_ld_op = '0; ex_mem_req = 1'b0; ex_excep = 1'b0; ex_side = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0; wb_allowin = 1'b1; wb_flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks = checks + 1;
    if ({mem_allowin, mem_to_wb_valid, mem_fwd_we, mem_ld_pending, mem_excep_out} !== 5'b10000) begin
      errors = errors + 1;
      $display("FAIL reset_ctrl got %b exp 10000",
               {mem_allowin, mem_to_wb_valid, mem_fwd_we, mem_ld_pending, mem_excep_out});
    end
    checks = checks + 1;
    if ({mem_pc, mem_rf_wdata, mem_rf_we, mem_rf_waddr, mem_side} !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_payload got pc=%h wdata=%h side=%h exp all zero", mem_pc, mem_rf_wdata, mem_side);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ld_b();
    push_exp(32'h100, 1'b1, 5'd5, 32'hFFFFFF80);
    enter(32'h100, 1'b1, 5'd5, 32'h1003, LD_B, 1'b1, 1'b0);
    @(negedge clk);
    checks = checks + 1;
    if ({mem_ld_pending, mem_to_wb_valid, mem_allowin} !== 3'b100) begin
      errors = errors + 1;
      $display("FAIL ldb_wait got pend/vld/allowin=%b exp 100", {mem_ld_pending, mem_to_wb_valid, mem_allowin});
    end
    tick();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80112233;
    @(negedge clk);
    checks = checks + 1;
    if ({mem_ld_pending, mem_to_wb_valid, mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata} !==
        {1'b0, 1'b1, 1'b1, 5'd5, 32'hFFFFFF80}) begin
      errors = errors + 1;
      $display("FAIL ldb_data got pend=%b vld=%b fwd_we=%b fwd_wa=%0d fwd_wdata=%h exp 0 1 1 5 ffffff80",
               mem_ld_pending, mem_to_wb_valid, mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata);
    end
    tick();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if ({mem_to_wb_valid, mem_allowin} !== 2'b01) begin
      errors = errors + 1;
      $display("FAIL ldb_drain got vld/allowin=%b exp 01", {mem_to_wb_valid, mem_allowin});
    end
  endtask

  // ld.hu then ld.h back-to-back, each answered in its first MEM cycle.
  task automatic test_back_to_back();
    push_exp(32'h200, 1'b1, 5'd6, 32'h00008001);
    push_exp(32'h204, 1'b1, 5'd7, 32'hFFFF8001);
    drive_ex(32'h200, 1'b1, 5'd6, 32'h2002, LD_HU, 1'b1, 1'b0);
    tick();
    drive_ex(32'h204, 1'b1, 5'd7, 32'h2002, LD_H, 1'b1, 1'b0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80011234;
    @(negedge clk);
    checks = checks + 1;
    if ({mem_to_wb_valid, mem_allowin, mem_rf_wdata} !== {2'b11, 32'h00008001}) begin
      errors = errors + 1;
      $display("FAIL ldhu got vld/allowin=%b wdata=%h exp 11 00008001", {mem_to_wb_valid, mem_allowin}, mem_rf_wdata);
    end
    tick();
    ex_to_mem_valid = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if ({mem_to_wb_valid, mem_rf_wdata} !== {1'b1, 32'hFFFF8001}) begin
      errors = errors + 1;
      $display("FAIL ldh got vld=%b wdata=%h exp 1 ffff8001", mem_to_wb_valid, mem_rf_wdata);
    end
    tick();
    data_sram_data_ok = 1'b0;
    push_exp(32'h208, 1'b1, 5'd8, 32'h00000022);
    enter(32'h208, 1'b1, 5'd8, 32'h2101, LD_BU, 1'b1, 1'b0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80112233;
    @(negedge clk);
    checks = checks + 1;
    if (mem_rf_wdata !== 32'h00000022) begin
      errors = errors + 1;
      $display("FAIL ldbu got wdata=%h exp 00000022", mem_rf_wdata);
    end
    tick();
    data_sram_data_ok = 1'b0;
    push_exp(32'h20C, 1'b1, 5'd9, 32'h80112233);
    enter(32'h20C, 1'b1, 5'd9, 32'h2200, LD_W, 1'b1, 1'b0);
    data_sram_data_ok = 1'b1;
    tick();
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_wb_stall();
    push_exp(32'h300, 1'b1, 5'd10, 32'h11223344);
    enter(32'h300, 1'b1, 5'd10, 32'h3000, LD_W, 1'b1, 1'b0);
    wb_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11223344;
    @(negedge clk);
    checks = checks + 1;
    if (mem_allowin !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL stall_allowin got %b exp 0", mem_allowin);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      data_sram_data_ok = 1'b0; data_sram_rdata = 32'hDEADBEEF;
      @(negedge clk);
      checks = checks + 1;
      if ({mem_to_wb_valid, mem_allowin, mem_ld_pending, mem_rf_wdata} !== {3'b100, 32'h11223344}) begin
        errors = errors + 1;
        $display("FAIL stall_hold%0d got vld/allowin/pend=%b wdata=%h exp 100 11223344",
                 i, {mem_to_wb_valid, mem_allowin, mem_ld_pending}, mem_rf_wdata);
      end
    end
    tick();
    wb_allowin = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if ({mem_to_wb_valid, mem_allowin} !== 2'b11) begin
      errors = errors + 1;
      $display("FAIL stall_release got vld/allowin=%b exp 11", {mem_to_wb_valid, mem_allowin});
    end
    tick();
  endtask

  task automatic test_flush_discard();
    enter(32'h400, 1'b1, 5'd11, 32'h4000, LD_W, 1'b1, 1'b0);
    wb_flush = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if (mem_to_wb_valid !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL flushw_vld got %b exp 0", mem_to_wb_valid);
    end
    tick();
    wb_flush = 1'b0;
    push_exp(32'h500, 1'b1, 5'd12, 32'hCAFEF00D);
    enter(32'h500, 1'b1, 5'd12, 32'h5000, LD_W, 1'b1, 1'b0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h12345678;
    @(negedge clk);
    checks = checks + 1;
    if ({mem_to_wb_valid, mem_ld_pending} !== 2'b01) begin
      errors = errors + 1;
      $display("FAIL flushw_drop got vld/pend=%b exp 01", {mem_to_wb_valid, mem_ld_pending});
    end
    tick();
    data_sram_rdata = 32'hCAFEF00D;
    @(negedge clk);
    checks = checks + 1;
    if ({mem_to_wb_valid, mem_rf_wdata} !== {1'b1, 32'hCAFEF00D}) begin
      errors = errors + 1;
      $display("FAIL flushw_take got vld=%b wdata=%h exp 1 cafef00d", mem_to_wb_valid, mem_rf_wdata);
    end
    tick();
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_flush_same_cycle();
    enter(32'h600, 1'b1, 5'd13, 32'h6000, LD_W, 1'b1, 1'b0);
    wb_flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h55555555;
    @(negedge clk);
    checks = checks + 1;
    if (mem_to_wb_valid !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL flushs_vld got %b exp 0", mem_to_wb_valid);
    end
    tick();
    wb_flush = 1'b0; data_sram_data_ok = 1'b0;
    push_exp(32'h700, 1'b1, 5'd14, 32'h0BADF00D);
    enter(32'h700, 1'b1, 5'd14, 32'h7000, LD_W, 1'b1, 1'b0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BADF00D;
    @(negedge clk);
    checks = checks + 1;
    if ({mem_to_wb_valid, mem_rf_wdata} !== {1'b1, 32'h0BADF00D}) begin
      errors = errors + 1;
      $display("FAIL flushs_next got vld=%b wdata=%h exp 1 0badf00d", mem_to_wb_valid, mem_rf_wdata);
    end
    tick();
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_alu_excep();
    push_exp(32'h800, 1'b1, 5'd7, 32'h00001234);
    enter(32'h800, 1'b1, 5'd7, 32'h1234, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks = checks + 1;
    if ({mem_to_wb_valid, mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata, mem_excep_out} !==
        {2'b11, 5'd7, 32'h00001234, 1'b0}) begin
      errors = errors + 1;
      $display("FAIL alu got vld=%b fwd_we=%b fwd_wa=%0d fwd_wdata=%h excep=%b exp 1 1 7 00001234 0",
               mem_to_wb_valid, mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata, mem_excep_out);
    end
    tick();
    push_exp(32'h900, 1'b0, 5'd0, 32'h00000ABC);
    enter(32'h900, 1'b0, 5'd0, 32'hABC, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    checks = checks + 1;
    if ({mem_to_wb_valid, mem_excep_out, mem_fwd_we} !== 3'b110) begin
      errors = errors + 1;
      $display("FAIL excep got vld/excep/fwd_we=%b exp 110", {mem_to_wb_valid, mem_excep_out, mem_fwd_we});
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    enter(32'hA00, 1'b1, 5'd15, 32'hA000, LD_W, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checks = checks + 1;
    if ({mem_allowin, mem_to_wb_valid, mem_ld_pending, mem_fwd_we} !== 4'b1000) begin
      errors = errors + 1;
      $display("FAIL reset_async got allowin/vld/pend/fwd_we=%b exp 1000",
               {mem_allowin, mem_to_wb_valid, mem_ld_pending, mem_fwd_we});
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_ld_b();
    test_back_to_back();
    test_wb_stall();
    test_flush_discard();
    test_flush_same_cycle();
    test_alu_excep();
    test_reset_mid_wait();
    repeat (2) tick();
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL sb_leftover got %0d pending entries exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
